tick_timer: RTL

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tick_timer.sv
// Tick-driven countdown timer.
// clk_100K is a slow strobe source sampled as data in the clk_in_50M domain.
// Each rising edge of clk_100K gives a one-cycle tick. The tick decrements a
// countdown that is loaded by start. The countdown can be paused, restarted or
// aborted.
module tick_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_in_50M,
  input  logic             reset,
  input  logic             clk_100K,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             q1_q,    q2_q;

  // Rising-edge detector on the sampled divider clock. Both taps reset high,
  // so a clk_100K that is already high at reset release cannot fake an edge.
  always_ff @(posedge clk_in_50M) begin
    if (reset) begin
      q1_q <= 1'b1;
      q2_q <= 1'b1;
    end else begin
      q1_q <= clk_100K;
      q2_q <= q1_q;
    end
  end

  assign tick = q1_q & ~q2_q;

  // State, count and status registers.
  always_ff @(posedge clk_in_50M) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Start takes precedence in every state, then pause,
  // then tick. A zero load expires immediately and does not enter RUN.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = load_val;
          if (load_val == CNT_ZERO) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (start) begin
          count_d = load_val;
          if (load_val == CNT_ZERO) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else if (count_q == CNT_ONE) begin
            count_d = CNT_ZERO;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            // A zero count in RUN cannot be reached. Park in IDLE without
            // emitting a done pulse.
            state_d = ST_IDLE;
          end
        end
      end

      ST_PAUSED: begin
        if (start) begin
          count_d = load_val;
          if (load_val == CNT_ZERO) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
